// File: rtl/vga_pkg.sv
// Shared constants, mode encodings and width helpers for the VGA test-pattern generator.
package vga_pkg;

   // Default 640x480@60 timing (25 MHz pixel clock)
   localparam int DEF_H_VIS  = 640;
   localparam int DEF_H_FP   = 16;
   localparam int DEF_H_SYNC = 96;
   localparam int DEF_H_BP   = 48;
   localparam int DEF_V_VIS  = 480;
   localparam int DEF_V_FP   = 10;
   localparam int DEF_V_SYNC = 2;
   localparam int DEF_V_BP   = 33;

   // Counter width able to hold 0..n-1; never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   typedef enum logic [1:0] {
      MODE_VBARS  = 2'd0,
      MODE_HBARS  = 2'd1,
      MODE_CHECK  = 2'd2,
      MODE_SCROLL = 2'd3
   } mode_e;

   // Colour index is {R,G,B}
   localparam logic [2:0] CI_BLACK = 3'd0;
   localparam logic [2:0] CI_BLUE  = 3'd1;
   localparam logic [2:0] CI_WHITE = 3'd7;

endpackage

// File: rtl/vga_if.sv
// VGA output bundle plus the pattern-select input.
interface vga_if #(
   parameter int COLOR_BITS = 1,
   parameter int COL_W      = 10,
   parameter int ROW_W      = 10
);
   logic [1:0]              mode;
   logic                    vga_hs_l;
   logic                    vga_vs_l;
   logic [3*COLOR_BITS-1:0] vga_rgb;
   logic [COL_W-1:0]        vga_col;
   logic [ROW_W-1:0]        vga_row;
   logic                    vga_display;
   logic                    frame_start;

   modport master (
      input  mode,
      output vga_hs_l, vga_vs_l, vga_rgb, vga_col, vga_row, vga_display, frame_start
   );

   modport slave (
      output mode,
      input  vga_hs_l, vga_vs_l, vga_rgb, vga_col, vga_row, vga_display, frame_start
   );
endinterface

// File: rtl/vga_timing.sv
// Pixel-rate divider, raster counters and next-pixel sync/display decode.
module vga_timing
   import vga_pkg::*;
#(
   parameter int  CLK_DIV = 2,
   parameter int  H_VIS   = DEF_H_VIS,
   parameter int  H_FP    = DEF_H_FP,
   parameter int  H_SYNC  = DEF_H_SYNC,
   parameter int  H_BP    = DEF_H_BP,
   parameter int  V_VIS   = DEF_V_VIS,
   parameter int  V_FP    = DEF_V_FP,
   parameter int  V_SYNC  = DEF_V_SYNC,
   parameter int  V_BP    = DEF_V_BP,
   localparam int H_TOT   = H_VIS + H_FP + H_SYNC + H_BP,
   localparam int V_TOT   = V_VIS + V_FP + V_SYNC + V_BP,
   localparam int COL_W   = cnt_w(H_TOT),
   localparam int ROW_W   = cnt_w(V_TOT)
) (
   input  logic             clk,
   input  logic             rst,
   output logic             pix_en,
   output logic [COL_W-1:0] h,
   output logic [ROW_W-1:0] v,
   output logic             hs_l_next,
   output logic             vs_l_next,
   output logic             display_next,
   output logic             line_end,
   output logic             frame_end
);
   localparam int DIV_W = cnt_w(CLK_DIV);

   logic [DIV_W-1:0] div_q, div_d;
   logic [COL_W-1:0] h_q, h_d;
   logic [ROW_W-1:0] v_q, v_d;
   logic             h_last, v_last;

   // Divider and raster counters; counters move only on the pixel enable
   always_comb begin
      pix_en       = (div_q == DIV_W'(CLK_DIV - 1));
      h_last       = (h_q == COL_W'(H_TOT - 1));
      v_last       = (v_q == ROW_W'(V_TOT - 1));
      div_d        = pix_en ? '0 : div_q + 1'b1;
      h_d          = h_q;
      v_d          = v_q;
      if (pix_en) begin
         h_d = h_last ? '0 : h_q + 1'b1;
         if (h_last) begin
            v_d = v_last ? '0 : v_q + 1'b1;
         end
      end
      line_end     = pix_en && h_last;
      frame_end    = line_end && v_last;
      hs_l_next    = !((h_q >= COL_W'(H_VIS + H_FP)) && (h_q < COL_W'(H_VIS + H_FP + H_SYNC)));
      vs_l_next    = !((v_q >= ROW_W'(V_VIS + V_FP)) && (v_q < ROW_W'(V_VIS + V_FP + V_SYNC)));
      display_next = (h_q < COL_W'(H_VIS)) && (v_q < ROW_W'(V_VIS));
      h            = h_q;
      v            = v_q;
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q <= '0;
         h_q   <= '0;
         v_q   <= '0;
      end else begin
         div_q <= div_d;
         h_q   <= h_d;
         v_q   <= v_d;
      end
   end

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: frame-latched mode, stripe counters, scroll offset,
// colour mux and the output register stage (one pixel period behind the counters).
module vga_pattern_gen
   import vga_pkg::*;
#(
   parameter int CLK_DIV     = 2,
   parameter int H_VIS       = DEF_H_VIS,
   parameter int H_FP        = DEF_H_FP,
   parameter int H_SYNC      = DEF_H_SYNC,
   parameter int H_BP        = DEF_H_BP,
   parameter int V_VIS       = DEF_V_VIS,
   parameter int V_FP        = DEF_V_FP,
   parameter int V_SYNC      = DEF_V_SYNC,
   parameter int V_BP        = DEF_V_BP,
   parameter int COLOR_BITS  = 1,
   parameter int CHECK_LOG2  = 5,
   parameter int BAR_W       = 32,
   parameter int SCROLL_STEP = 4
) (
   input logic   clk,
   input logic   rst,
   vga_if.master bus
);
   localparam int H_TOT     = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT     = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int COL_W     = cnt_w(H_TOT);
   localparam int ROW_W     = cnt_w(V_TOT);
   localparam int CS_STRIDE = H_VIS / 8;
   localparam int RS_STRIDE = V_VIS / 8;
   localparam int CS_W      = cnt_w(CS_STRIDE);
   localparam int RS_W      = cnt_w(RS_STRIDE);
   localparam int RGB_W     = 3 * COLOR_BITS;

   logic             pix_en, hs_l_next, vs_l_next, display_next, line_end, frame_end;
   logic [COL_W-1:0] h;
   logic [ROW_W-1:0] v;

   mode_e            active_mode_q, active_mode_d;
   logic [COL_W-1:0] offset_q, offset_d;
   logic [CS_W-1:0]  cs_pos_q, cs_pos_d;
   logic [2:0]       cs_idx_q, cs_idx_d;
   logic [RS_W-1:0]  rs_pos_q, rs_pos_d;
   logic [2:0]       rs_idx_q, rs_idx_d;

   logic             hs_l_q, hs_l_d, vs_l_q, vs_l_d;
   logic [RGB_W-1:0] rgb_q, rgb_d;
   logic [COL_W-1:0] col_q, col_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic             display_q, display_d, frame_start_q, frame_start_d;

   logic [COL_W-1:0] rel;
   logic [2:0]       ci;

   vga_timing #(
      .CLK_DIV (CLK_DIV),
      .H_VIS   (H_VIS),
      .H_FP    (H_FP),
      .H_SYNC  (H_SYNC),
      .H_BP    (H_BP),
      .V_VIS   (V_VIS),
      .V_FP    (V_FP),
      .V_SYNC  (V_SYNC),
      .V_BP    (V_BP)
   ) u_timing (
      .clk          (clk),
      .rst          (rst),
      .pix_en       (pix_en),
      .h            (h),
      .v            (v),
      .hs_l_next    (hs_l_next),
      .vs_l_next    (vs_l_next),
      .display_next (display_next),
      .line_end     (line_end),
      .frame_end    (frame_end)
   );

   // Pattern state: stripe counters track h/v without a divider; mode and offset change only at frame end
   always_comb begin
      active_mode_d = active_mode_q;
      offset_d      = offset_q;
      cs_pos_d      = cs_pos_q;
      cs_idx_d      = cs_idx_q;
      rs_pos_d      = rs_pos_q;
      rs_idx_d      = rs_idx_q;
      if (pix_en) begin
         if (line_end) begin
            cs_pos_d = '0;
            cs_idx_d = '0;
         end else if (cs_pos_q == CS_W'(CS_STRIDE - 1)) begin
            cs_pos_d = '0;
            cs_idx_d = cs_idx_q + 1'b1;
         end else begin
            cs_pos_d = cs_pos_q + 1'b1;
         end
      end
      if (frame_end) begin
         rs_pos_d      = '0;
         rs_idx_d      = '0;
         active_mode_d = mode_e'(bus.mode);
         // Compare before adding so the sum never needs a wider register
         offset_d      = (offset_q >= COL_W'(H_VIS - SCROLL_STEP))
                       ? offset_q - COL_W'(H_VIS - SCROLL_STEP)
                       : offset_q + COL_W'(SCROLL_STEP);
      end else if (line_end) begin
         if (rs_pos_q == RS_W'(RS_STRIDE - 1)) begin
            rs_pos_d = '0;
            rs_idx_d = rs_idx_q + 1'b1;
         end else begin
            rs_pos_d = rs_pos_q + 1'b1;
         end
      end
   end

   // Colour selection and the output stage, loaded once per pixel
   always_comb begin
      rel = (h >= offset_q) ? h - offset_q : COL_W'(H_VIS) - (offset_q - h);
      case (active_mode_q)
         MODE_VBARS: ci = cs_idx_q;
         MODE_HBARS: ci = rs_idx_q;
         MODE_CHECK: ci = (h[CHECK_LOG2] ^ v[CHECK_LOG2]) ? CI_WHITE : CI_BLACK;
         default:    ci = (rel < COL_W'(BAR_W)) ? CI_WHITE : CI_BLUE;
      endcase
      hs_l_d        = hs_l_q;
      vs_l_d        = vs_l_q;
      rgb_d         = rgb_q;
      col_d         = col_q;
      row_d         = row_q;
      display_d     = display_q;
      frame_start_d = 1'b0;
      if (pix_en) begin
         hs_l_d        = hs_l_next;
         vs_l_d        = vs_l_next;
         rgb_d         = display_next ? {{COLOR_BITS{ci[2]}}, {COLOR_BITS{ci[1]}}, {COLOR_BITS{ci[0]}}}
                                      : '0;
         col_d         = h;
         row_d         = v;
         display_d     = display_next;
         frame_start_d = (h == '0) && (v == '0);
      end
   end

   // All pattern and output registers, synchronous reset to the inactive state
   always_ff @(posedge clk) begin
      if (rst) begin
         active_mode_q <= MODE_VBARS;
         offset_q      <= '0;
         cs_pos_q      <= '0;
         cs_idx_q      <= '0;
         rs_pos_q      <= '0;
         rs_idx_q      <= '0;
         hs_l_q        <= 1'b1;
         vs_l_q        <= 1'b1;
         rgb_q         <= '0;
         col_q         <= '0;
         row_q         <= '0;
         display_q     <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         active_mode_q <= active_mode_d;
         offset_q      <= offset_d;
         cs_pos_q      <= cs_pos_d;
         cs_idx_q      <= cs_idx_d;
         rs_pos_q      <= rs_pos_d;
         rs_idx_q      <= rs_idx_d;
         hs_l_q        <= hs_l_d;
         vs_l_q        <= vs_l_d;
         rgb_q         <= rgb_d;
         col_q         <= col_d;
         row_q         <= row_d;
         display_q     <= display_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign bus.vga_hs_l    = hs_l_q;
   assign bus.vga_vs_l    = vs_l_q;
   assign bus.vga_rgb     = rgb_q;
   assign bus.vga_col     = col_q;
   assign bus.vga_row     = row_q;
   assign bus.vga_display = display_q;
   assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench: a small 24x12 raster at CLK_DIV=1 (instance a) and CLK_DIV=3 (instance b).
module tb_vga_pattern_gen;

   logic clk;
   logic rst_a, rst_b;
   int   n_err;
   int   n_checks;
   logic [2:0] snap [0:287];

   // {hs_l, vs_l, display, frame_start, rgb[2:0], col[4:0], row[3:0]}
   localparam logic [15:0] RST_PIX = 16'hC000;

   vga_if #(.COLOR_BITS(1), .COL_W(5), .ROW_W(4)) bus_a ();
   vga_if #(.COLOR_BITS(1), .COL_W(5), .ROW_W(4)) bus_b ();

   vga_pattern_gen #(
      .CLK_DIV(1), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .COLOR_BITS(1), .CHECK_LOG2(1), .BAR_W(4), .SCROLL_STEP(6)
   ) u_dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   vga_pattern_gen #(
      .CLK_DIV(3), .H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
      .V_VIS(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .COLOR_BITS(1), .CHECK_LOG2(1), .BAR_W(4), .SCROLL_STEP(6)
   ) u_dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected output word for a pixel of the 24x12 raster
   function automatic logic [15:0] exp_pix(input logic [1:0] m, input int off,
                                           input int col, input int row, input logic fs);
      logic [2:0] ci;
      logic       dsp;
      dsp = (col < 16) && (row < 8);
      case (m)
         2'd0:    ci = 3'(col / 2);
         2'd1:    ci = 3'(row);
         2'd2:    ci = (((col >> 1) ^ (row >> 1)) & 1) != 0 ? 3'd7 : 3'd0;
         default: ci = (((col - off + 16) % 16) < 4) ? 3'd7 : 3'd1;
      endcase
      return {!(col >= 18 && col < 22), !(row >= 9 && row < 11), dsp, fs,
              dsp ? ci : 3'd0, 5'(col), 4'(row)};
   endfunction

   function automatic logic [15:0] obs_a();
      return {bus_a.vga_hs_l, bus_a.vga_vs_l, bus_a.vga_display, bus_a.frame_start,
              bus_a.vga_rgb, bus_a.vga_col, bus_a.vga_row};
   endfunction

   function automatic logic [15:0] obs_b();
      return {bus_b.vga_hs_l, bus_b.vga_vs_l, bus_b.vga_display, bus_b.frame_start,
              bus_b.vga_rgb, bus_b.vga_col, bus_b.vga_row};
   endfunction

   // Walk one frame of instance a (pixel p visible on the p-th negedge), optionally changing mode mid-frame
   task automatic frame_a(input logic [1:0] m, input int off, input int stop,
                          input int chg_at, input logic [1:0] chg_mode);
      int hs_lo, vs_lo, fs_n;
      hs_lo = 0;
      vs_lo = 0;
      fs_n  = 0;
      for (int p = 0; p < stop; p++) begin
         @(negedge clk);
         if (p == chg_at) bus_a.mode = chg_mode;
         snap[p] = bus_a.vga_rgb;
         if (!bus_a.vga_hs_l) hs_lo++;
         if (!bus_a.vga_vs_l) vs_lo++;
         if (bus_a.frame_start) fs_n++;
         check_eq($sformatf("pix_a m%0d off%0d p%0d", m, off, p), 32'(obs_a()),
                  32'(exp_pix(m, off, p % 24, p / 24, p == 0)));
      end
      if (stop == 288) begin
         check_eq("hs_low_clks", 32'(hs_lo), 32'd48);
         check_eq("vs_low_clks", 32'(vs_lo), 32'd48);
         check_eq("frame_start_cnt", 32'(fs_n), 32'd1);
      end
   endtask

   initial begin
      int fs_b;
      logic [15:0] expw;
      n_err      = 0;
      n_checks   = 0;
      rst_a      = 1'b1;
      rst_b      = 1'b1;
      bus_a.mode = 2'd0;
      bus_b.mode = 2'd0;

      repeat (3) @(negedge clk);
      check_eq("reset_a", 32'(obs_a()), 32'(RST_PIX));
      rst_a = 1'b0;

      // vbars, switch to checker at row 3
      frame_a(2'd0, 0, 288, 72, 2'd2);
      check_eq("vbar_c4", 32'(snap[4]), 32'd2);
      check_eq("vbar_c15", 32'(snap[15]), 32'd7);
      check_eq("vbar_blank", 32'(snap[16]), 32'd0);

      // checker with 2-pixel cells
      frame_a(2'd2, 6, 288, 100, 2'd3);
      check_eq("chk_0_0", 32'(snap[0]), 32'd0);
      check_eq("chk_2_0", 32'(snap[2]), 32'd7);

      // scroll: offsets 12, 2, 8, 14
      frame_a(2'd3, 12, 288, -1, 2'd0);
      check_eq("scr12_c12", 32'(snap[12]), 32'd7);
      check_eq("scr12_c11", 32'(snap[11]), 32'd1);
      frame_a(2'd3, 2, 288, -1, 2'd0);
      check_eq("scr2_c2", 32'(snap[2]), 32'd7);
      check_eq("scr2_c1", 32'(snap[1]), 32'd1);
      frame_a(2'd3, 8, 288, -1, 2'd0);
      frame_a(2'd3, 14, 288, 50, 2'd1);
      check_eq("scr14_c14", 32'(snap[14]), 32'd7);
      check_eq("scr14_c15", 32'(snap[15]), 32'd7);
      check_eq("scr14_c0", 32'(snap[0]), 32'd7);
      check_eq("scr14_c1", 32'(snap[1]), 32'd7);
      check_eq("scr14_c2", 32'(snap[2]), 32'd1);
      check_eq("scr14_c13", 32'(snap[13]), 32'd1);

      // hbars: rgb equals row index across the whole row
      frame_a(2'd1, 4, 288, -1, 2'd0);
      for (int r = 0; r < 8; r++) begin
         check_eq($sformatf("hbar_r%0d", r), 32'(snap[r * 24 + 5]), 32'(r));
      end

      // reset for one clk at row 2 col 19 (inside hsync)
      frame_a(2'd1, 10, 68, -1, 2'd0);
      rst_a = 1'b1;
      @(negedge clk);
      check_eq("reset_mid", 32'(obs_a()), 32'(RST_PIX));
      rst_a = 1'b0;
      // mode input still 1, but the active mode restarts at vbars and offset at 0
      frame_a(2'd0, 0, 288, -1, 2'd0);
      check_eq("post_rst_vbar_c4", 32'(snap[4]), 32'd2);
      frame_a(2'd1, 6, 288, -1, 2'd0);

      // instance b: CLK_DIV=3, each pixel held for 3 clks
      rst_b = 1'b0;
      fs_b  = 0;
      for (int n = 1; n <= 870; n++) begin
         @(negedge clk);
         if (n < 3) begin
            expw = RST_PIX;
         end else begin
            int p, k, pp;
            p    = (n - 3) / 3;
            k    = (n - 3) % 3;
            pp   = p % 288;
            expw = exp_pix(2'd0, 0, pp % 24, pp / 24, (pp == 0) && (k == 0));
         end
         if (bus_b.frame_start) fs_b++;
         check_eq($sformatf("pix_b n%0d", n), 32'(obs_b()), 32'(expw));
      end
      check_eq("frame_start_cnt_b", 32'(fs_b), 32'd2);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
